seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, 100000, clock cycles per digit slot (>= 2).
REQ-002 Parameter GAP, 2000, blanking cycles at slot start (1 <= GAP < CLK_DIV), anti-ghosting.
REQ-003 Parameter LZB, 1, 1 = blank leading zero digits, 0 = show all digits.
REQ-004 CLK  in  1  single system clock, all logic on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 EN  in  1  1 = scan display, 0 = display off.
REQ-007 DATA  in  16  four BCD digits, [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-008 DP_IN  in  4  decimal point per digit, 1 = lit, bit i = digit i.
REQ-009 LOAD  in  1  one-cycle strobe, capture DATA/DP_IN.
REQ-010 PENDING  out  1  captured value waiting for frame boundary.
REQ-011 COUNT  out  4  digit code to the 7-segment decoder.
REQ-012 SA  out  4  digit select, active-low, bit i = digit i.
REQ-013 DP  out  1  decimal point, active-low.
REQ-014 FRAME  out  1  one-cycle pulse at each frame boundary.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 States: OFF, GAP_PH, DRIVE. OFF when EN=0: SA=1111, DP=1, slot counter and digit index held at 0.
REQ-017 OFF->GAP_PH on the first cycle EN=1; digit index starts at 0.
REQ-018 Each slot SHALL last exactly CLK_DIV cycles: GAP cycles in GAP_PH (SA=1111, DP=1), then CLK_DIV-GAP cycles in DRIVE.
REQ-019 In DRIVE, SA SHALL drive only bit idx low; COUNT = shadow digit idx; DP = ~shadow_dp[idx].
REQ-020 COUNT SHALL update at GAP_PH entry so it is stable before SA enables the digit.
REQ-021 At slot end, idx SHALL increment mod 4 (3->0 wraps); FRAME SHALL pulse for one cycle on the 3->0 wrap only.
REQ-022 LZB=1: digit i (i=3..1) SHALL be blanked (SA bit stays 1, DP still shown) when it and all higher digits are 0 and its DP bit is 0; digit 0 is never blanked.
REQ-023 BCD digit values 10..15 SHALL be passed to COUNT unchanged (the decoder shows its error glyph).
REQ-024 LOAD SHALL capture DATA/DP_IN into a pending register and set PENDING=1 the next cycle.
REQ-025 LOAD while PENDING=1: the pending register is overwritten, so the latest value wins.
REQ-026 At a frame boundary with PENDING=1: shadow <= pending, PENDING <= 0 (no mid-frame tearing).
REQ-027 LOAD in the same cycle as a boundary: DATA SHALL go straight to shadow and PENDING stays 0.
REQ-028 While EN=0, frame boundaries do not occur; a pending value SHALL transfer to shadow in the cycle OFF is left.
REQ-029 EN falling mid-slot SHALL force OFF the next cycle; pending and shadow registers are kept.

Reset
REQ-030 RST SHALL force: state OFF, idx 0, slot counter 0, shadow 0, pending 0, PENDING 0, COUNT 0000, SA 1111, DP 1, FRAME 0.
REQ-031 RST SHALL take priority over EN and LOAD in the same cycle.

Structure
REQ-032 Shared package: state enum (OFF, GAP_PH, DRIVE), SA_OFF constant 4'b1111, digit count constant 4.
REQ-033 One sub-module, seg7_slot_timer: a CLK_DIV counter giving gap_done and slot_end strobes.
REQ-034 The top SHALL instantiate the existing 7-segment decoder only at board level; it is not inside this block.

Verification (CLK_DIV=4, GAP=1, LZB=1)
REQ-035 RST, EN=1, LOAD DATA=16'h1234, DP_IN=0000 -> first frame shows 0000 blanked-pattern, then SA cycles 1110/1101/1011/0111 with COUNT 4,3,2,1; each low SA for 3 cycles after 1 cycle of 1111.
REQ-036 DATA=16'h0007 loaded -> only SA=1110 goes low (COUNT=7); slots 1..3 keep SA=1111; DATA=16'h0000 -> digit 0 shows 0.
REQ-037 LOAD 16'h1111 then 16'h2222 mid-frame -> PENDING=1 until FRAME; the next frame shows only 2s.
REQ-038 LOAD asserted on the FRAME cycle with 16'h5555 -> PENDING never rises; the next slot shows COUNT=5.
REQ-039 EN dropped mid-DRIVE -> SA=1111 next cycle; EN re-raised -> scan restarts at digit 0 GAP_PH.
REQ-040 RST asserted mid-frame with LOAD=1 -> all outputs at REQ-030 values the next cycle; the LOAD is ignored.

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// rtl/seg7_scan_ctrl_pkg.sv - shared constants and helpers for the 7-segment scan controller
package seg7_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] SA_OFF = 4'b1111;

  // Scan states: display off, blanking gap at slot start, digit driven.
  typedef logic [1:0] state_t;
  localparam state_t ST_OFF    = 2'd0;
  localparam state_t ST_GAP_PH = 2'd1;
  localparam state_t ST_DRIVE  = 2'd2;

  // Digits 3..1 are blanked while they and every higher digit are zero and their
  // own decimal point is unlit; digit 0 always shows.
  function automatic logic [3:0] lead_blank(input logic [15:0] digits, input logic [3:0] dps);
    logic       zero_above;
    logic [3:0] mask;
    mask       = 4'b0000;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (digits[4*i +: 4] == 4'd0);
      mask[i]    = zero_above & ~dps[i];
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// rtl/seg7_slot_timer.sv - per-slot cycle counter with gap and slot-end strobes
module seg7_slot_timer #(
  parameter int CLK_DIV = 100000,
  parameter int GAP     = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic gap_done,
  output logic slot_end,
  output logic pre_end
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  // Count cycles within a slot; held at zero whenever the scan is not running.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign gap_done = (cnt == CW'(GAP - 1));
  assign slot_end = (cnt == CW'(CLK_DIV - 1));
  // One cycle ahead of slot_end, so the registered frame pulse lines up with the wrap.
  assign pre_end  = (cnt == CW'(CLK_DIV - 2));

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - four-digit multiplexed 7-segment scan controller
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int GAP     = 2000,
  parameter int LZB     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        pending,
  output logic [3:0]  count,
  output logic [3:0]  sa,
  output logic        dp,
  output logic        frame
);

  state_t      st;
  logic [1:0]  idx;
  logic [1:0]  next_idx;
  logic [15:0] sh, pd, sh_nx;
  logic [3:0]  sh_dp, pd_dp, shdp_nx;
  logic [3:0]  blank;
  logic        run, bnd;
  logic        gap_done, slot_end, pre_end;

  assign run      = (st != ST_OFF) && en;
  assign next_idx = idx + 2'd1;
  // Frame boundary: the 3->0 wrap, or leaving OFF (so a value loaded while off shows at once).
  assign bnd      = en && ((st == ST_OFF) || ((st == ST_DRIVE) && slot_end && (idx == 2'd3)));
  assign blank    = (LZB != 0) ? lead_blank(sh, sh_dp) : 4'b0000;

  seg7_slot_timer #(.CLK_DIV(CLK_DIV), .GAP(GAP)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .gap_done (gap_done),
    .slot_end (slot_end),
    .pre_end  (pre_end)
  );

  // Shadow value as it will be after this edge; a load on a boundary bypasses pending.
  always_comb begin
    sh_nx   = sh;
    shdp_nx = sh_dp;
    if (bnd) begin
      if (load) begin
        sh_nx   = data;
        shdp_nx = dp_in;
      end else if (pending) begin
        sh_nx   = pd;
        shdp_nx = pd_dp;
      end
    end
  end

  // Double-buffered display value: loads park in pending until a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh      <= '0;
      sh_dp   <= '0;
      pd      <= '0;
      pd_dp   <= '0;
      pending <= 1'b0;
    end else begin
      sh    <= sh_nx;
      sh_dp <= shdp_nx;
      if (bnd) begin
        pending <= 1'b0;
      end else if (load) begin
        pd      <= data;
        pd_dp   <= dp_in;
        pending <= 1'b1;
      end
    end
  end

  // Scan sequencing with registered digit select, code, decimal point and frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= ST_OFF;
      idx   <= 2'd0;
      count <= 4'd0;
      sa    <= SA_OFF;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else if (!en) begin
      st    <= ST_OFF;
      idx   <= 2'd0;
      sa    <= SA_OFF;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else begin
      case (st)
        ST_OFF: begin
          st    <= ST_GAP_PH;
          idx   <= 2'd0;
          count <= sh_nx[3:0];
          sa    <= SA_OFF;
          dp    <= 1'b1;
          frame <= 1'b0;
        end
        ST_GAP_PH: begin
          frame <= pre_end && (idx == 2'd3);
          if (gap_done) begin
            st <= ST_DRIVE;
            sa <= blank[idx] ? SA_OFF : ~(4'b0001 << idx);
            dp <= ~sh_dp[idx];
          end
        end
        ST_DRIVE: begin
          frame <= pre_end && (idx == 2'd3);
          if (slot_end) begin
            st    <= ST_GAP_PH;
            idx   <= next_idx;
            count <= sh_nx[{next_idx, 2'b00} +: 4];
            sa    <= SA_OFF;
            dp    <= 1'b1;
          end
        end
        default: begin
          st  <= ST_OFF;
          idx <= 2'd0;
          sa  <= SA_OFF;
          dp  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  localparam int CD = 4;
  localparam int GP = 1;
  localparam int LZ = 1;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        pending;
  logic [3:0]  count, sa;
  logic        dp, frame;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.CLK_DIV(CD), .GAP(GP), .LZB(LZ)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .data    (data),
    .dp_in   (dp_in),
    .load    (load),
    .pending (pending),
    .count   (count),
    .sa      (sa),
    .dp      (dp),
    .frame   (frame)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: scan position is simply cycles since the scan started.
  bit          m_on;
  int          m_t;
  logic [15:0] m_sh, m_pd;
  logic [3:0]  m_shdp, m_pddp;
  bit          m_pend;
  logic [3:0]  m_cnt;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpv;
    logic [15:0] sa4;
    logic [15:0] cnt4;
    logic [3:0]  dp4;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] digit_of(input logic [15:0] v, input int i);
    return 4'((v >> (4 * i)) & 16'hF);
  endfunction

  function automatic bit m_blank(input int i);
    if (LZ == 0 || i == 0) return 1'b0;
    for (int j = i; j < 4; j++) if (digit_of(m_sh, j) != 4'd0) return 1'b0;
    return !m_shdp[i];
  endfunction

  function automatic bit frame_now();
    return m_on && (m_t % CD == CD - 1) && ((m_t / CD) % 4 == 3);
  endfunction

  task automatic model_step();
    int ph, ix;
    bit bnd;
    if (rst) begin
      m_on = 0; m_t = 0; m_sh = '0; m_shdp = '0; m_pd = '0; m_pddp = '0; m_pend = 0; m_cnt = '0;
    end else begin
      ph  = m_t % CD;
      ix  = (m_t / CD) % 4;
      bnd = en && (!m_on || (ph == CD - 1 && ix == 3));
      if (bnd) begin
        if (load) begin
          m_sh = data; m_shdp = dp_in;
        end else if (m_pend) begin
          m_sh = m_pd; m_shdp = m_pddp;
        end
        m_pend = 0;
      end else if (load) begin
        m_pd = data; m_pddp = dp_in; m_pend = 1;
      end
      if (!en) begin
        m_on = 0; m_t = 0;
      end else if (!m_on) begin
        m_on = 1; m_t = 0;
      end else begin
        m_t++;
      end
      if (m_on) m_cnt = digit_of(m_sh, (m_t / CD) % 4);
    end
  endtask

  task automatic check_model();
    int ph, ix;
    logic [3:0] esa;
    logic edp;
    esa = 4'hF;
    edp = 1'b1;
    if (m_on) begin
      ph = m_t % CD;
      ix = (m_t / CD) % 4;
      if (ph >= GP) begin
        if (!m_blank(ix)) esa[ix] = 1'b0;
        edp = ~m_shdp[ix];
      end
    end
    check("model_sa", {12'd0, sa}, {12'd0, esa});
    check("model_dp", {15'd0, dp}, {15'd0, edp});
    check("model_count", {12'd0, count}, {12'd0, m_cnt});
    check("model_frame", {15'd0, frame}, {15'd0, frame_now()});
    check("model_pending", {15'd0, pending}, {15'd0, m_pend});
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic wait_frame();
    for (int k = 0; k < 40 && !frame_now(); k++) step();
    check("wait_frame", {15'd0, frame_now()}, 16'd1);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 16'h7BDE, 16'h1234, 4'b1111};
    vecs[1] = '{16'h0007, 4'b0000, 16'hFFFE, 16'h0007, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, 16'hFFFE, 16'h0000, 4'b1111};
    vecs[3] = '{16'h0000, 4'b0100, 16'hFBFE, 16'h0000, 4'b1011};
    vecs[4] = '{16'h0A05, 4'b0000, 16'hFBDE, 16'h0A05, 4'b1111};
    vecs[5] = '{16'hF000, 4'b0001, 16'h7BDE, 16'hF000, 4'b1110};
    vecs[6] = '{16'h00C0, 4'b1000, 16'h7FDE, 16'h00C0, 4'b0111};

    rst = 1'b1; en = 1'b0; load = 1'b0; data = '0; dp_in = '0;
    step();
    check("reset_sa", {12'd0, sa}, 16'hF);
    check("reset_count", {12'd0, count}, 16'h0);
    check("reset_pending", {15'd0, pending}, 16'h0);
    rst = 1'b0;
    en  = 1'b1;
    step();
    step();

    // Blanking and digit ordering vectors: load, let the frame swap in, check each slot.
    foreach (vecs[v]) begin
      load = 1'b1; data = vecs[v].data; dp_in = vecs[v].dpv;
      step();
      load = 1'b0;
      wait_frame();
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < CD; c++) begin
          step();
          if (c == GP) begin
            check($sformatf("vec%0d_sa%0d", v, d), {12'd0, sa}, {12'd0, vecs[v].sa4[4*d +: 4]});
            check($sformatf("vec%0d_cnt%0d", v, d), {12'd0, count}, {12'd0, vecs[v].cnt4[4*d +: 4]});
            check($sformatf("vec%0d_dp%0d", v, d), {15'd0, dp}, {15'd0, vecs[v].dp4[d]});
          end
        end
      end
    end

    // Load on the frame cycle goes straight to shadow.
    check("on_frame", {15'd0, frame}, 16'd1);
    load = 1'b1; data = 16'h5555; dp_in = 4'b0000;
    step();
    load = 1'b0;
    check("bypass_pending", {15'd0, pending}, 16'd0);
    check("bypass_count", {12'd0, count}, 16'd5);

    // Two loads mid-frame: latest wins at the frame boundary.
    step(); step(); step();
    load = 1'b1; data = 16'h1111;
    step();
    check("pend_set", {15'd0, pending}, 16'd1);
    data = 16'h2222;
    step();
    load = 1'b0;
    check("pend_hold", {15'd0, pending}, 16'd1);
    wait_frame();
    step();
    check("pend_clear", {15'd0, pending}, 16'd0);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("latest_cnt%0d", d), {12'd0, count}, 16'd2);
      for (int c = 0; c < CD; c++) step();
    end

    // Enable drop mid-drive, then restart from digit 0.
    for (int k = 0; k < 20 && (!m_on || (m_t % CD) < GP); k++) step();
    en = 1'b0;
    step();
    check("en_off_sa", {12'd0, sa}, 16'hF);
    step(); step();
    en = 1'b1;
    step();
    check("restart_gap_sa", {12'd0, sa}, 16'hF);
    check("restart_count", {12'd0, count}, 16'd2);
    step();
    check("restart_drive_sa", {12'd0, sa}, 16'hE);

    // Reset beats a simultaneous load.
    step(); step(); step();
    rst = 1'b1; load = 1'b1; data = 16'h9999;
    step();
    rst = 1'b0; load = 1'b0;
    check("rst_sa", {12'd0, sa}, 16'hF);
    check("rst_count", {12'd0, count}, 16'd0);
    check("rst_pending", {15'd0, pending}, 16'd0);
    check("rst_frame", {15'd0, frame}, 16'd0);
    check("rst_dp", {15'd0, dp}, 16'd1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) en = ~en;
      load = ($urandom_range(0, 7) == 0);
      for (int d = 0; d < 4; d++) data[4*d +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      dp_in = 4'($urandom & $urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
